instruction_fetch_unit: RTL and testbench

//  Supplies instruction words to Control_Unit and the register-file decode path. Owns the PC and

---
 rtl/mips_cpu_pkg.sv | 20 ++
 rtl/instruction_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: fetch FSM states, reset vector, word size.
// Also used by the instruction-memory bus models.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_HOLD,
    IFU_HALTED
  } ifu_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one read at a time on the
// instruction-memory bus (waitrequest handshake) and hands each word to
// decode with valid/ready. Execute can redirect the PC at any time.
// Optional feature macro: IFU_HALT_DETECT_EN -- entering a fetch of address 0
// halts the unit (active=0) until reset.
module instruction_fetch_unit
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] program_counter,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        active
);

  ifu_state_t  r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_pend, w_pend_nxt;
  logic [31:0] r_tgt, w_tgt_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_prog_counter;
  logic        r_valid;
  logic        w_load;
  logic        w_vld_clr;
  logic        w_halt;

  // The request is a pure function of state, so an async reset drops it at once.
  assign mem_read          = (r_state == IFU_REQ);
  assign mem_address       = r_pc;
  assign instruction       = r_instr;
  assign instruction_valid = r_valid;
  assign program_counter   = r_prog_counter;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IFU_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, next PC and redirect bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_tgt_nxt   = r_tgt;
    w_load      = 1'b0;
    w_vld_clr   = 1'b0;
    w_halt      = 1'b0;
    case (r_state)
      IFU_IDLE: w_state_nxt = IFU_REQ;
      IFU_REQ: begin
        if (!mem_waitrequest) begin
          // A redirect seen now or during the stall makes the returned word stale.
          if (redirect_valid) begin
            w_pc_nxt   = word_align(redirect_target);
            w_pend_nxt = 1'b0;
          end else if (r_pend) begin
            w_pc_nxt   = r_tgt;
            w_pend_nxt = 1'b0;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = IFU_HOLD;
          end
        end else if (redirect_valid) begin
          // Address must not change mid-request; remember the newest target.
          w_pend_nxt = 1'b1;
          w_tgt_nxt  = word_align(redirect_target);
        end
      end
      IFU_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = word_align(redirect_target);
          w_vld_clr   = 1'b1;
          w_state_nxt = IFU_REQ;
        end else if (instruction_ready) begin
          w_pc_nxt    = r_pc + INSTR_BYTES;
          w_vld_clr   = 1'b1;
          w_state_nxt = IFU_REQ;
        end
      end
      IFU_HALTED: w_state_nxt = IFU_HALTED;
      default:    w_state_nxt = IFU_IDLE;
    endcase
`ifdef IFU_HALT_DETECT_EN
    // Never issue a read to address 0: park instead.
    if ((w_state_nxt == IFU_REQ) && (w_pc_nxt == 32'h0)) begin
      w_halt      = 1'b1;
      w_state_nxt = IFU_HALTED;
    end
`endif
  end

  // PC, pending redirect and the word presented to decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc           <= RESET_VECTOR;
      r_pend         <= 1'b0;
      r_tgt          <= '0;
      r_instr        <= '0;
      r_prog_counter <= RESET_VECTOR;
      r_valid        <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_pend <= w_pend_nxt;
      r_tgt  <= w_tgt_nxt;
      if (w_load) begin
        r_instr        <= mem_readdata;
        r_prog_counter <= r_pc;
        r_valid        <= 1'b1;
      end else if (w_vld_clr) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef IFU_HALT_DETECT_EN
  logic r_active;

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_active <= 1'b1;
    else if (w_halt) r_active <= 1'b0;
  end

  assign active = r_active;
`else
  logic w_unused_halt;
  assign w_unused_halt = w_halt;
  assign active        = 1'b1;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus pushes expected read
// addresses and expected (pc, word) handoffs; monitors pop and compare.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] program_counter;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        active;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_word_t;

  logic [31:0] addr_q[$];
  exp_word_t   word_q[$];
  int          n_pass = 0;
  int          n_tot  = 0;
  logic        done   = 1'b0;

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .instruction       (instruction),
    .instruction_valid (instruction_valid),
    .instruction_ready (instruction_ready),
    .program_counter   (program_counter),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .active            (active)
  );

  always #5 clk = ~clk;

  // Memory model: one fixed opcode at the reset vector, inverted address elsewhere.
  assign mem_readdata = (mem_address == 32'hBFC0_0000) ? 32'h2408_0005 : ~mem_address;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!instruction_valid && n < 20);
    chk({name, "_valid_seen"}, {31'd0, instruction_valid}, 32'd1);
  endtask

  // Accepted read requests must come out in the expected address order.
  always @(negedge clk) begin
    if (!done && reset_n && mem_read && !mem_waitrequest) begin
      if (addr_q.size() == 0) chk("unexpected_read", mem_address, 32'hxxxx_xxxx);
      else chk("read_addr", mem_address, addr_q.pop_front());
    end
  end

  // Every handoff to decode must match the next expected (pc, word).
  always @(negedge clk) begin
    exp_word_t e;
    if (!done && reset_n && instruction_valid && instruction_ready) begin
      if (word_q.size() == 0) chk("unexpected_handoff", program_counter, 32'hxxxx_xxxx);
      else begin
        e = word_q.pop_front();
        chk("handoff_pc", program_counter, e.pc);
        chk("handoff_word", instruction, e.word);
      end
    end
  end

  initial begin
    logic [31:0] held_i;
    reset_n = 1'b0; mem_waitrequest = 1'b1; instruction_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_address", mem_address, 32'hBFC0_0000);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_valid", {31'd0, instruction_valid}, 32'd0);
    chk("rst_program_counter", program_counter, 32'hBFC0_0000);
    chk("rst_active", {31'd0, active}, 32'd1);

    // First fetch, zero wait: valid at second edge after release
    addr_q.push_back(32'hBFC0_0000);
    word_q.push_back('{32'hBFC0_0000, 32'h2408_0005});
    mem_waitrequest = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("e1_valid", {31'd0, instruction_valid}, 32'd0);
    chk("e1_mem_read", {31'd0, mem_read}, 32'd1);
    tick();
    chk("e2_valid", {31'd0, instruction_valid}, 32'd1);
    chk("e2_instruction", instruction, 32'h2408_0005);
    chk("e2_mem_read", {31'd0, mem_read}, 32'd0);
    mem_waitrequest = 1'b1; instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;

    // Stalled request at pc+4: address and read held
    for (int i = 0; i < 3; i++) begin
      chk("stall_mem_read", {31'd0, mem_read}, 32'd1);
      chk("stall_mem_address", mem_address, 32'hBFC0_0004);
      tick();
    end
    addr_q.push_back(32'hBFC0_0004);
    word_q.push_back('{32'hBFC0_0004, 32'h403F_FFFB});
    mem_waitrequest = 1'b0;
    wait_valid("stall");
    mem_waitrequest = 1'b1;

    // Decode back-pressure: outputs frozen, no read, pc not advanced
    held_i = instruction;
    for (int i = 0; i < 5; i++) begin
      chk("bp_instruction", instruction, held_i);
      chk("bp_program_counter", program_counter, 32'hBFC0_0004);
      chk("bp_mem_read", {31'd0, mem_read}, 32'd0);
      chk("bp_mem_address", mem_address, 32'hBFC0_0004);
      tick();
    end
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;

    // Redirect during a stalled request: completes at old address, data dropped
    chk("rq_addr_before", mem_address, 32'hBFC0_0008);
    redirect_valid = 1'b1; redirect_target = 32'hBFC0_0100;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("rq_addr_stable", mem_address, 32'hBFC0_0008);
    addr_q.push_back(32'hBFC0_0008);
    addr_q.push_back(32'hBFC0_0100);
    word_q.push_back('{32'hBFC0_0100, 32'h403F_FEFF});
    mem_waitrequest = 1'b0;
    tick();
    chk("rq_discard_valid", {31'd0, instruction_valid}, 32'd0);
    chk("rq_new_addr", mem_address, 32'hBFC0_0100);
    wait_valid("rq");
    chk("rq_program_counter", program_counter, 32'hBFC0_0100);
    mem_waitrequest = 1'b1;

    // Redirect in HOLD together with ready; target low bits ignored, no pc+4 fetch
    redirect_valid = 1'b1; redirect_target = 32'hBFC0_0203; instruction_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; instruction_ready = 1'b0;
    chk("hold_rd_valid", {31'd0, instruction_valid}, 32'd0);
    chk("hold_rd_mem_read", {31'd0, mem_read}, 32'd1);
    chk("hold_rd_addr", mem_address, 32'hBFC0_0200);
    addr_q.push_back(32'hBFC0_0200);
    word_q.push_back('{32'hBFC0_0200, 32'h403F_FDFF});
    mem_waitrequest = 1'b0;
    wait_valid("hold_rd");
    mem_waitrequest = 1'b1;

    // Top of address space, then wrap to 0
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; instruction_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; instruction_ready = 1'b0;
    chk("top_addr", mem_address, 32'hFFFF_FFFC);
    addr_q.push_back(32'hFFFF_FFFC);
    word_q.push_back('{32'hFFFF_FFFC, 32'h0000_0003});
    mem_waitrequest = 1'b0;
    wait_valid("top");
    mem_waitrequest = 1'b1; instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
`ifdef IFU_HALT_DETECT_EN
    chk("halt_active", {31'd0, active}, 32'd0);
    chk("halt_mem_read", {31'd0, mem_read}, 32'd0);
    chk("halt_valid", {31'd0, instruction_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'hBFC0_0000;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("halt_ignores_redirect", {31'd0, mem_read}, 32'd0);
    chk("halt_sticky", {31'd0, active}, 32'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("halt_reset_active", {31'd0, active}, 32'd1);
    addr_q.push_back(32'hBFC0_0000);
    word_q.push_back('{32'hBFC0_0000, 32'h2408_0005});
    mem_waitrequest = 1'b0;
    wait_valid("resume");
    mem_waitrequest = 1'b1; instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
`else
    chk("wrap_mem_read", {31'd0, mem_read}, 32'd1);
    chk("wrap_addr", mem_address, 32'h0000_0000);
    chk("wrap_active", {31'd0, active}, 32'd1);
    addr_q.push_back(32'h0000_0000);
    word_q.push_back('{32'h0000_0000, 32'hFFFF_FFFF});
    mem_waitrequest = 1'b0;
    wait_valid("wrap");
    mem_waitrequest = 1'b1; instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    chk("wrap_next_addr", mem_address, 32'h0000_0004);
`endif

    // Reset in the middle of a stalled request: read drops asynchronously
    chk("mid_mem_read", {31'd0, mem_read}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("mid_rst_addr", mem_address, 32'hBFC0_0000);
    chk("mid_rst_valid", {31'd0, instruction_valid}, 32'd0);
    tick();
    done = 1'b1;

    chk("addr_q_drained", addr_q.size(), 32'd0);
    chk("word_q_drained", word_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
